// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and the default-slave state type.
package ahb_lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ERR1,
        ERR2,
        OKAY
    } dslv_state_t;

endpackage

// File: rtl/default_slave_err_log.sv
// Fault log for the default slave: saturating count, last faulting address and
// direction, sticky valid flag and a one-cycle interrupt pulse.
module default_slave_err_log #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  HCLK,
    input  logic                  HRESETN,
    input  logic                  log_en,
    input  logic                  clr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  write,
    output logic                  irq,
    output logic                  valid,
    output logic [CNT_WIDTH-1:0]  count,
    output logic [ADDR_WIDTH-1:0] last_addr,
    output logic                  last_write
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic                  r_irq;
    logic                  r_valid;
    logic [CNT_WIDTH-1:0]  r_count;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_write;

    // A clear coinciding with a new error acts first, so the new error counts as one.
    always_ff @(posedge HCLK or posedge HRESETN) begin
        if (HRESETN) begin
            r_irq   <= 1'b0;
            r_valid <= 1'b0;
            r_count <= '0;
            r_addr  <= '0;
            r_write <= 1'b0;
        end else begin
            r_irq <= log_en;
            if (log_en) begin
                r_valid <= 1'b1;
                r_addr  <= addr;
                r_write <= write;
                if (clr) begin
                    r_count <= CNT_WIDTH'(1);
                end else if (r_count != CNT_MAX) begin
                    r_count <= r_count + 1'b1;
                end
            end else if (clr) begin
                r_valid <= 1'b0;
                r_count <= '0;
            end
        end
    end

    assign irq        = r_irq;
    assign valid      = r_valid;
    assign count      = r_count;
    assign last_addr  = r_addr;
    assign last_write = r_write;

endmodule

// File: rtl/ahb_lite_default_slave_v2.sv
// AHB-Lite default slave for unmapped space: optional wait states, then either a
// two-cycle ERROR or a RAZ/WI OKAY, with faulting transfers logged.
module ahb_lite_default_slave_v2
    import ahb_lite_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 0,
    parameter int ERROR_EN    = 1,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                  HCLK,
    input  logic                  HRESETN,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  err_clr,
    output logic                  err_irq,
    output logic                  err_valid,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic                  err_write
);

    localparam int                 WCNT_W       = 4;
    localparam logic [WCNT_W-1:0]  WAIT_LOAD    = (WAIT_STATES > 0) ? WCNT_W'(WAIT_STATES - 1) : '0;
    localparam dslv_state_t        RESP_STATE   = (ERROR_EN != 0) ? ERR1 : OKAY;
    localparam dslv_state_t        ACCEPT_STATE = (WAIT_STATES > 0) ? WAIT : RESP_STATE;

    dslv_state_t       r_state;
    dslv_state_t       w_next;
    logic [WCNT_W-1:0] r_waitCnt;
    logic              w_loadWait;
    logic              w_accept;
    logic              w_logEn;
    logic              r_hreadyout;
    logic              r_hresp;
    logic              w_hreadyout;
    logic              w_hresp;
    logic [2:0]        r_hsize;
    logic              w_unused;

    assign w_accept = HSEL & HREADY & HTRANS[1];
    assign w_logEn  = w_accept && (ERROR_EN != 0);

    // Outputs are decoded from the next state so they are registered with it.
    always_ff @(posedge HCLK or posedge HRESETN) begin
        if (HRESETN) begin
            r_state     <= IDLE;
            r_waitCnt   <= '0;
            r_hreadyout <= 1'b1;
            r_hresp     <= HRESP_OKAY;
        end else begin
            r_state     <= w_next;
            r_hreadyout <= w_hreadyout;
            r_hresp     <= w_hresp;
            if (w_loadWait) begin
                r_waitCnt <= WAIT_LOAD;
            end else if (r_state == WAIT && r_waitCnt != '0) begin
                r_waitCnt <= r_waitCnt - 1'b1;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_loadWait = 1'b0;
        case (r_state)
            IDLE, ERR2, OKAY: begin
                if (w_accept) begin
                    w_next     = ACCEPT_STATE;
                    w_loadWait = (WAIT_STATES > 0);
                end else begin
                    w_next = IDLE;
                end
            end
            WAIT: begin
                if (r_waitCnt == '0) begin
                    w_next = RESP_STATE;
                end
            end
            ERR1:    w_next = ERR2;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_hreadyout = 1'b1;
        w_hresp     = HRESP_OKAY;
        case (w_next)
            WAIT: w_hreadyout = 1'b0;
            ERR1: begin
                w_hreadyout = 1'b0;
                w_hresp     = HRESP_ERROR;
            end
            ERR2:    w_hresp = HRESP_ERROR;
            default: ;
        endcase
    end

    // Transfer size is kept only as address-phase context; nothing consumes it.
    always_ff @(posedge HCLK or posedge HRESETN) begin
        if (HRESETN) begin
            r_hsize <= '0;
        end else if (w_accept) begin
            r_hsize <= HSIZE;
        end
    end

    assign w_unused = ^{HBURST, HWDATA, HTRANS[0], r_hsize};

    assign HREADYOUT = r_hreadyout;
    assign HRESP     = r_hresp;
    assign HRDATA    = '0;

    default_slave_err_log #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_errLog (
        .HCLK      (HCLK),
        .HRESETN   (HRESETN),
        .log_en    (w_logEn),
        .clr       (err_clr),
        .addr      (HADDR),
        .write     (HWRITE),
        .irq       (err_irq),
        .valid     (err_valid),
        .count     (err_count),
        .last_addr (err_addr),
        .last_write(err_write)
    );

endmodule

// File: tb/tb_ahb_lite_default_slave_v2.sv
// Directed bench for the default slave: four instances cover error, wait-state,
// RAZ/WI and small-counter configurations; each HREADY loops back from HREADYOUT.
`timescale 1ns/1ps
module tb_ahb_lite_default_slave_v2;

    logic        HCLK = 1'b0;
    logic        HRESETN;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;

    logic        selA, selB, selC, selD;
    logic        clrA, clrB, clrC, clrD;
    logic        readyA, readyB, readyC, readyD;
    logic        respA, respB, respC, respD;
    logic [31:0] rdataA, rdataB, rdataC, rdataD;
    logic        irqA, irqB, irqC, irqD;
    logic        validA, validB, validC, validD;
    logic [7:0]  countA, countB, countC;
    logic [1:0]  countD;
    logic [31:0] addrA, addrB, addrC, addrD;
    logic        writeA, writeB, writeC, writeD;

    int assertCount = 0;
    int failCount   = 0;

    always #5 HCLK = ~HCLK;

    ahb_lite_default_slave_v2 #(.WAIT_STATES(0), .ERROR_EN(1), .CNT_WIDTH(8)) dutA (
        .HCLK(HCLK), .HRESETN(HRESETN), .HSEL(selA), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(readyA),
        .HREADYOUT(readyA), .HRESP(respA), .HRDATA(rdataA), .err_clr(clrA), .err_irq(irqA),
        .err_valid(validA), .err_count(countA), .err_addr(addrA), .err_write(writeA)
    );

    ahb_lite_default_slave_v2 #(.WAIT_STATES(3), .ERROR_EN(1), .CNT_WIDTH(8)) dutB (
        .HCLK(HCLK), .HRESETN(HRESETN), .HSEL(selB), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(readyB),
        .HREADYOUT(readyB), .HRESP(respB), .HRDATA(rdataB), .err_clr(clrB), .err_irq(irqB),
        .err_valid(validB), .err_count(countB), .err_addr(addrB), .err_write(writeB)
    );

    ahb_lite_default_slave_v2 #(.WAIT_STATES(0), .ERROR_EN(0), .CNT_WIDTH(8)) dutC (
        .HCLK(HCLK), .HRESETN(HRESETN), .HSEL(selC), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(readyC),
        .HREADYOUT(readyC), .HRESP(respC), .HRDATA(rdataC), .err_clr(clrC), .err_irq(irqC),
        .err_valid(validC), .err_count(countC), .err_addr(addrC), .err_write(writeC)
    );

    ahb_lite_default_slave_v2 #(.WAIT_STATES(0), .ERROR_EN(1), .CNT_WIDTH(2)) dutD (
        .HCLK(HCLK), .HRESETN(HRESETN), .HSEL(selD), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(readyD),
        .HREADYOUT(readyD), .HRESP(respD), .HRDATA(rdataD), .err_clr(clrD), .err_irq(irqD),
        .err_valid(validD), .err_count(countD), .err_addr(addrD), .err_write(writeD)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] selMask, input logic [1:0] trans,
                                 input logic [31:0] addr, input logic write);
        {selD, selC, selB, selA} = selMask;
        htrans = trans;
        haddr  = addr;
        hwrite = write;
        hsize  = 3'b010;
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin
        HRESETN = 1'b1;
        hburst  = 3'b000;
        hwdata  = 32'h0;
        {clrA, clrB, clrC, clrD} = 4'b0000;
        applyStimulus(4'b0000, 2'b00, 32'h0, 1'b0);
        tick();
        tick();
        checkOutput("rst_hreadyout", 64'(readyA), 64'h1);
        checkOutput("rst_hresp",     64'(respA),  64'h0);
        checkOutput("rst_hrdata",    64'(rdataA), 64'h0);
        checkOutput("rst_count",     64'(countA), 64'h0);
        checkOutput("rst_valid",     64'(validA), 64'h0);
        checkOutput("rst_irq",       64'(irqA),   64'h0);
        HRESETN = 1'b0;
        tick();

        // Reset arriving in the middle of an ERROR response
        applyStimulus(4'b0001, 2'b10, 32'h1234_0000, 1'b1);
        tick();
        applyStimulus(4'b0000, 2'b00, 32'h0, 1'b0);
        checkOutput("midrst_err1_ready", 64'(readyA), 64'h0);
        checkOutput("midrst_err1_resp",  64'(respA),  64'h1);
        #2 HRESETN = 1'b1;
        #1;
        checkOutput("midrst_async_ready", 64'(readyA), 64'h1);
        checkOutput("midrst_async_resp",  64'(respA),  64'h0);
        tick();
        HRESETN = 1'b0;
        checkOutput("midrst_count", 64'(countA), 64'h0);
        checkOutput("midrst_valid", 64'(validA), 64'h0);
        checkOutput("midrst_irq",   64'(irqA),   64'h0);
        checkOutput("midrst_addr",  64'(addrA),  64'h0);
        checkOutput("midrst_write", 64'(writeA), 64'h0);
        tick();

        // Zero-wait two-cycle ERROR on a read
        applyStimulus(4'b0001, 2'b10, 32'h4000_0000, 1'b0);
        tick();
        applyStimulus(4'b0000, 2'b00, 32'h0, 1'b0);
        checkOutput("A_err1_ready", 64'(readyA), 64'h0);
        checkOutput("A_err1_resp",  64'(respA),  64'h1);
        checkOutput("A_irq",        64'(irqA),   64'h1);
        checkOutput("A_addr",       64'(addrA),  64'h4000_0000);
        checkOutput("A_write",      64'(writeA), 64'h0);
        checkOutput("A_count",      64'(countA), 64'h1);
        checkOutput("A_valid",      64'(validA), 64'h1);
        tick();
        checkOutput("A_err2_ready", 64'(readyA), 64'h1);
        checkOutput("A_err2_resp",  64'(respA),  64'h1);
        checkOutput("A_irq_pulse",  64'(irqA),   64'h0);
        tick();
        checkOutput("A_idle_ready", 64'(readyA), 64'h1);
        checkOutput("A_idle_resp",  64'(respA),  64'h0);

        // Three wait states ahead of the ERROR pair on a write
        applyStimulus(4'b0010, 2'b10, 32'h5000_0010, 1'b1);
        tick();
        applyStimulus(4'b0000, 2'b00, 32'h0, 1'b0);
        checkOutput("B_irq",   64'(irqB),   64'h1);
        checkOutput("B_write", 64'(writeB), 64'h1);
        checkOutput("B_addr",  64'(addrB),  64'h5000_0010);
        for (int i = 0; i < 3; i++) begin
            checkOutput("B_wait_ready", 64'(readyB), 64'h0);
            checkOutput("B_wait_resp",  64'(respB),  64'h0);
            tick();
        end
        checkOutput("B_err1_ready", 64'(readyB), 64'h0);
        checkOutput("B_err1_resp",  64'(respB),  64'h1);
        tick();
        checkOutput("B_err2_ready", 64'(readyB), 64'h1);
        checkOutput("B_err2_resp",  64'(respB),  64'h1);
        tick();
        checkOutput("B_idle_resp", 64'(respB),  64'h0);
        checkOutput("B_count",     64'(countB), 64'h1);

        // RAZ/WI instance: OKAY, zero read data, nothing logged
        hwdata = 32'hDEAD_BEEF;
        hburst = 3'b011;
        applyStimulus(4'b0100, 2'b10, 32'h6000_0000, 1'b0);
        tick();
        applyStimulus(4'b0000, 2'b00, 32'h0, 1'b0);
        checkOutput("C_okay_ready", 64'(readyC), 64'h1);
        checkOutput("C_okay_resp",  64'(respC),  64'h0);
        checkOutput("C_hrdata",     64'(rdataC), 64'h0);
        checkOutput("C_irq",        64'(irqC),   64'h0);
        tick();
        checkOutput("C_count", 64'(countC), 64'h0);
        checkOutput("C_valid", 64'(validC), 64'h0);
        hwdata = 32'h0;
        hburst = 3'b000;

        // Clear alone keeps the captured address; IDLE and BUSY log nothing
        clrA = 1'b1;
        tick();
        clrA = 1'b0;
        checkOutput("A_clr_count", 64'(countA), 64'h0);
        checkOutput("A_clr_valid", 64'(validA), 64'h0);
        checkOutput("A_clr_addr",  64'(addrA),  64'h4000_0000);
        applyStimulus(4'b0001, 2'b00, 32'h4000_0100, 1'b0);
        tick();
        checkOutput("A_idle_sel_ready", 64'(readyA), 64'h1);
        checkOutput("A_idle_sel_resp",  64'(respA),  64'h0);
        checkOutput("A_idle_sel_irq",   64'(irqA),   64'h0);
        applyStimulus(4'b0001, 2'b01, 32'h4000_0104, 1'b1);
        tick();
        checkOutput("A_busy_ready", 64'(readyA), 64'h1);
        checkOutput("A_busy_resp",  64'(respA),  64'h0);
        checkOutput("A_busy_count", 64'(countA), 64'h0);

        // Back-to-back: second NONSEQ held through ERR1, accepted during ERR2
        applyStimulus(4'b0001, 2'b10, 32'h7000_0004, 1'b1);
        tick();
        applyStimulus(4'b0001, 2'b10, 32'h7000_0008, 1'b0);
        checkOutput("A_b2b_err1_resp", 64'(respA),  64'h1);
        checkOutput("A_b2b_count1",    64'(countA), 64'h1);
        tick();
        checkOutput("A_b2b_err2_ready", 64'(readyA), 64'h1);
        checkOutput("A_b2b_err2_resp",  64'(respA),  64'h1);
        tick();
        applyStimulus(4'b0000, 2'b00, 32'h0, 1'b0);
        checkOutput("A_b2b_err1b_ready", 64'(readyA), 64'h0);
        checkOutput("A_b2b_err1b_resp",  64'(respA),  64'h1);
        checkOutput("A_b2b_count2",      64'(countA), 64'h2);
        checkOutput("A_b2b_addr",        64'(addrA),  64'h7000_0008);
        checkOutput("A_b2b_irq",         64'(irqA),   64'h1);
        tick();
        tick();
        checkOutput("A_b2b_idle_resp", 64'(respA), 64'h0);

        // Two-bit counter saturates at 3
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b1000, (i % 2 == 0) ? 2'b10 : 2'b11, 32'h8000_0000 + 32'(i * 4), 1'b0);
            tick();
            applyStimulus(4'b0000, 2'b00, 32'h0, 1'b0);
            checkOutput("D_count_sat", 64'(countD), (i + 1 > 3) ? 64'd3 : 64'(i + 1));
            tick();
            tick();
        end
        checkOutput("D_valid", 64'(validD), 64'h1);
        applyStimulus(4'b1000, 2'b10, 32'h8000_00F0, 1'b1);
        clrD = 1'b1;
        tick();
        clrD = 1'b0;
        applyStimulus(4'b0000, 2'b00, 32'h0, 1'b0);
        checkOutput("D_clr_err_count", 64'(countD), 64'h1);
        checkOutput("D_clr_err_valid", 64'(validD), 64'h1);
        checkOutput("D_clr_err_addr",  64'(addrD),  64'h8000_00F0);
        checkOutput("D_clr_err_write", 64'(writeD), 64'h1);
        checkOutput("D_clr_err_irq",   64'(irqD),   64'h1);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/ahb_lite_default_slave_v2.md
Name: ahb_lite_default_slave_v2

Overview:
Parametrised AHB-Lite default slave. The decoder selects it for unmapped address space. It answers IDLE/BUSY with zero-wait OKAY and answers NONSEQ/SEQ either with a spec-correct two-cycle ERROR response or with RAZ/WI OKAY. Each answer can be delayed by configurable wait states. It also logs faulting transfers (saturating count, last address/direction, interrupt pulse) for the system controller. It sits on the slave side of the AHB-Lite interconnect next to the address decoder.

Parameters:
ADDR_WIDTH, 32, HADDR width.
DATA_WIDTH, 32, HWDATA/HRDATA width; legal values 32 or 64.
WAIT_STATES, 0, wait cycles before the response; legal range 0..15.
ERROR_EN, 1, 1 = two-cycle ERROR for active transfers; 0 = RAZ/WI OKAY.
CNT_WIDTH, 8, width of the saturating error counter.

Ports:
HCLK  in  1  bus clock; all logic on rising edge.
HRESETN  in  1  asynchronous, active-high reset: 1 = in reset. Only HCLK and HRESETN; no other clock or reset.
HSEL  in  1  slave select from decoder.
HADDR  in  ADDR_WIDTH  address-phase address.
HTRANS  in  2  transfer type.
HWRITE  in  1  1 = write.
HSIZE  in  3  transfer size; captured only.
HBURST  in  3  burst type; ignored.
HWDATA  in  DATA_WIDTH  write data; ignored (WI).
HREADY  in  1  bus-level ready.
HREADYOUT  out  1  slave ready.
HRESP  out  1  0 = OKAY, 1 = ERROR (AHB-Lite single bit).
HRDATA  out  DATA_WIDTH  constant 0.
err_clr  in  1  synchronous clear of the error log.
err_irq  out  1  one-cycle pulse per logged error.
err_valid  out  1  sticky; set by an error, cleared by err_clr.
err_count  out  CNT_WIDTH  saturating count of errors.
err_addr  out  ADDR_WIDTH  HADDR of the most recent error.
err_write  out  1  HWRITE of the most recent error.

Behaviour:
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, err_irq=0, err_valid=0, err_count=0, err_addr=0, err_write=0. State = IDLE, wait counter = 0.
- Reset takes effect immediately, including mid-response. HREADYOUT returns to 1 asynchronously.
- HREADYOUT and HRESP are registered. HRDATA is tied to 0.
- A transfer is accepted at an edge where HSEL & HREADY & HTRANS[1] all hold. The sampled address-phase info is HADDR, HWRITE and HSIZE.
- IDLE (HTRANS=00) or BUSY (HTRANS=01) when selected: stay in IDLE. The next data phase is HREADYOUT=1, HRESP=0.
- States and transitions:
  - IDLE → WAIT on accept if WAIT_STATES>0. Load the counter with WAIT_STATES-1.
  - IDLE → ERR1 on accept if WAIT_STATES=0 and ERROR_EN=1.
  - IDLE → OKAY on accept if WAIT_STATES=0 and ERROR_EN=0.
  - WAIT: HREADYOUT=0, HRESP=0. Decrement the counter. At 0, go to ERR1 (ERROR_EN=1) or OKAY (ERROR_EN=0).
  - ERR1: HREADYOUT=0, HRESP=1. Always go to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1.
  - OKAY: HREADYOUT=1, HRESP=0.
- In ERR2 and OKAY, HREADY is high, so a new accept in that cycle goes to WAIT/ERR1/OKAY exactly as from IDLE (back-to-back). Otherwise return to IDLE.
- Latency, accept at edge k:
  - WAIT_STATES=N, ERROR_EN=1: HREADYOUT=0 for N+1 cycles, then ERR2. HRESP=1 only in the last two of the N+2 data-phase cycles.
  - ERROR_EN=0: N wait cycles, then one OKAY cycle.
- Writes are discarded; reads return 0.
- Error log:
  - A logged error is an accept while ERROR_EN=1. With ERROR_EN=0 nothing is logged and err_irq stays 0.
  - On a logged error (pulse at edge k+1): err_irq=1 for one cycle, err_valid=1, err_addr/err_write updated to the new transfer, err_count incremented.
  - err_count saturates at 2^CNT_WIDTH-1 and never wraps.
  - err_clr alone: err_count=0, err_valid=0. err_addr/err_write are held.
  - err_clr and a logged error at the same edge: clear is applied first, so err_count=1, err_valid=1, and the new address is captured.
- HBURST and HWDATA have no effect on any output.

Decomposition:
- Package ahb_lite_pkg holds:
  - HTRANS encodings: IDLE/BUSY/NONSEQ/SEQ.
  - HRESP_OKAY/HRESP_ERROR constants.
  - the dslv_state_t enum {IDLE, WAIT, ERR1, ERR2, OKAY}.
- Sub-module default_slave_err_log holds the counter, capture registers and irq. Its inputs are log_en, clr, addr, write.
- The top level contains the FSM and the wait counter.

Test Plan:
- Reset: assert HRESETN=1 mid-ERR1 → HREADYOUT=1, HRESP=0 immediately. After release, all log outputs are 0.
- WAIT_STATES=0, ERROR_EN=1: NONSEQ read at 0x4000_0000 → cycle1 HREADYOUT=0/HRESP=1, cycle2 1/1. err_irq pulses; err_addr=0x4000_0000, err_write=0, err_count=1.
- WAIT_STATES=3, ERROR_EN=1: NONSEQ write → 3 cycles 0/0, then 0/1, then 1/1. err_write=1.
- ERROR_EN=0, WAIT_STATES=0: NONSEQ read → single 1/0 with HRDATA=0. err_irq never asserts; err_count stays 0.
- HSEL=1 with HTRANS=IDLE, then BUSY → 1/0 each cycle, no log activity. A NONSEQ accepted during ERR2 → a new ERR1/ERR2 pair follows immediately, and err_count=2.
- CNT_WIDTH=2: 5 errors → err_count stays 3. err_clr on the same edge as a 6th error → err_count=1, err_valid=1.
